block_avg_downsampler: RTL and testbench

//  Parametrised streaming block-average downsampler. Takes a raster-order IMG_W x IMG_H image over a valid/ready stream.

---
 rtl/ds_pkg.sv | 32 +++
 rtl/ds_accum_line.sv | 33 +++
 rtl/block_avg_downsampler.sv | 152 +++++++++++++++
 tb/tb_block_avg_downsampler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared types and size helpers for the block-average downsampler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ds_state_e;

    // Output frame edge (width or height) before padding
    function automatic int f_out_dim(input int img_dim, input int blk_log2);
        return img_dim >> blk_log2;
    endfunction

    // Output frame edge including the zero border on both sides
    function automatic int f_pad_dim(input int out_dim, input int pad);
        return out_dim + 2 * pad;
    endfunction

    // Accumulator width: a full block of max pixels never overflows
    function automatic int f_acc_w(input int pix_w, input int blk_log2);
        return pix_w + 2 * blk_log2;
    endfunction

    // Address width spanning the whole padded output frame
    function automatic int f_addr_w(input int pw, input int ph);
        return $clog2(pw * ph);
    endfunction

endpackage

// File: rtl/ds_accum_line.sv
// One accumulator per output column of the current block row.
// Latency: read is combinational, write lands at the next clock edge.
// Backpressure: none; the caller only writes on accepted pixels.
module ds_accum_line #(
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 14,
    parameter int DEPTH  = 28,
    parameter int IDX_W  = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             load,
    input  logic [IDX_W-1:0] idx,
    input  logic [PIX_W-1:0] din,
    output logic [ACC_W-1:0] rd_data
);

    logic [ACC_W-1:0] mem [DEPTH];

    assign rd_data = mem[idx];

    // Clear-and-load on the first pixel of a block, accumulate otherwise
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (load) begin
                mem[idx] <= ACC_W'(din);
            end else begin
                mem[idx] <= mem[idx] + ACC_W'(din);
            end
        end
    end

endmodule

// File: rtl/block_avg_downsampler.sv
// Streaming block-average downsampler writing a zero-padded output frame; DS_ROUND_EN selects round-half-up over truncation.
// Latency: one cycle from the last pixel of a block to its SRAM write.
// Backpressure: pix_ready only in RUN (and not during start); input stalls are lossless.
module block_avg_downsampler
    import ds_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int IMG_W    = 224,
    parameter int IMG_H    = 224,
    parameter int BLK_LOG2 = 3,
    parameter int PAD      = 2,
    localparam int OUT_W   = f_out_dim(IMG_W, BLK_LOG2),
    localparam int OUT_H   = f_out_dim(IMG_H, BLK_LOG2),
    localparam int PW      = f_pad_dim(OUT_W, PAD),
    localparam int PH      = f_pad_dim(OUT_H, PAD),
    localparam int ADDR_W  = f_addr_w(PW, PH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              pix_ready,
    output logic              out_wr,
    output logic [PIX_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int ACC_W  = f_acc_w(PIX_W, BLK_LOG2);
    localparam int SHIFT  = 2 * BLK_LOG2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int BIDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int BROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    ds_state_e state, state_nxt;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BIDX_W-1:0] bc;
    logic [BROW_W-1:0] br;
    logic              accept;
    logic              col_last, row_last, frame_last;
    logic              blk_first, blk_last;
    logic [ACC_W-1:0]  acc_rd;
    logic [ACC_W-1:0]  sum;
    logic [PIX_W-1:0]  avg;
    logic [ADDR_W-1:0] blk_addr;

    // A pixel offered in the same cycle as start is dropped, so ready is withheld then
    assign accept     = pix_valid & pix_ready;
    assign col_last   = (col == COL_W'(IMG_W - 1));
    assign row_last   = (row == ROW_W'(IMG_H - 1));
    assign frame_last = col_last & row_last;
    assign blk_first  = (col[BLK_LOG2-1:0] == '0) && (row[BLK_LOG2-1:0] == '0);
    assign blk_last   = (&col[BLK_LOG2-1:0]) && (&row[BLK_LOG2-1:0]);
    assign bc         = BIDX_W'(col >> BLK_LOG2);
    assign br         = BROW_W'(row >> BLK_LOG2);

    ds_accum_line #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W),
        .DEPTH (OUT_W),
        .IDX_W (BIDX_W)
    ) u_accum (
        .clk     (clk),
        .wr_en   (accept),
        .load    (blk_first),
        .idx     (bc),
        .din     (pix_in),
        .rd_data (acc_rd)
    );

    // Block total including the pixel being accepted this cycle
    assign sum = acc_rd + ACC_W'(pix_in);

`ifdef DS_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
    assign avg = PIX_W'((sum + RND) >> SHIFT);
`else
    assign avg = PIX_W'(sum >> SHIFT);
`endif

    assign blk_addr = ADDR_W'((32'(br) + PAD) * PW + 32'(bc) + PAD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start wins from any state, FLUSH lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (accept && frame_last) state_nxt = FLUSH;
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs; done marks the cycle carrying the final block write
    always_comb begin
        pix_ready = (state == RUN) && !start;
        busy      = (state == RUN) || (state == FLUSH);
        done      = (state == FLUSH);
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Registered SRAM write for each completed block; data/addr hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            out_wr <= accept && blk_last;
            if (accept && blk_last) begin
                out_data <= avg;
                out_addr <= blk_addr;
            end
        end
    end

endmodule

// File: tb/tb_block_avg_downsampler.sv
// Directed bench: full-size instance for the 224x224 frame cases, reduced 16x16 instance for ramp/random/restart.
module tb_block_avg_downsampler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Full-size instance (default parameters)
    logic       start_b, pv_b, pr_b, wr_b, busy_b, done_b;
    logic [7:0] px_b, dat_b;
    logic [9:0] addr_b;

    // Reduced instance: 16x16, 4x4 blocks, pad 1 -> 6x6 padded frame
    logic       start_s, pv_s, pr_s, wr_s, busy_s, done_s;
    logic [7:0] px_s, dat_s;
    logic [5:0] addr_s;

    block_avg_downsampler u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .pix_valid (pv_b),
        .pix_in    (px_b),
        .pix_ready (pr_b),
        .out_wr    (wr_b),
        .out_data  (dat_b),
        .out_addr  (addr_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    block_avg_downsampler #(
        .PIX_W    (8),
        .IMG_W    (16),
        .IMG_H    (16),
        .BLK_LOG2 (2),
        .PAD      (1)
    ) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .pix_valid (pv_s),
        .pix_in    (px_s),
        .pix_ready (pr_s),
        .out_wr    (wr_s),
        .out_data  (dat_s),
        .out_addr  (addr_s),
        .busy      (busy_s),
        .done      (done_s)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Write capture
    int dq_b[$], aq_b[$], dq_s[$], aq_s[$];
    int nd_b = 0, nd_s = 0, dw_b = 0, dw_s = 0;

    always @(negedge clk) begin
        if (wr_b) begin
            dq_b.push_back(int'(dat_b));
            aq_b.push_back(int'(addr_b));
        end
        if (done_b) begin
            nd_b++;
            dw_b = wr_b ? dq_b.size() : -1;
        end
        if (wr_s) begin
            dq_s.push_back(int'(dat_s));
            aq_s.push_back(int'(addr_s));
        end
        if (done_s) begin
            nd_s++;
            dw_s = wr_s ? dq_s.size() : -1;
        end
    end

    task automatic clr_b();
        dq_b.delete(); aq_b.delete(); nd_b = 0; dw_b = 0;
    endtask

    task automatic clr_s();
        dq_s.delete(); aq_s.delete(); nd_s = 0; dw_s = 0;
    endtask

    task automatic start_pulse_b();
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic start_pulse_s();
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] p);
        bit got = 1'b0;
        pv_b = 1'b1;
        px_b = p;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            if (pr_b) begin
                got = 1'b1;
                @(posedge clk); #1;
            end
        end
        pv_b = 1'b0;
        if (!got) chk("b_push_timeout", int'(pr_b), 1);
    endtask

    task automatic push_s(input logic [7:0] p, input bit stall);
        bit got = 1'b0;
        if (stall && $urandom_range(1) == 1) begin
            pv_s = 1'b0;
            px_s = 8'hxx;
            @(posedge clk); #1;
        end
        pv_s = 1'b1;
        px_s = p;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            if (pr_s) begin
                got = 1'b1;
                @(posedge clk); #1;
            end
        end
        pv_s = 1'b0;
        if (!got) chk("s_push_timeout", int'(pr_s), 1);
    endtask

    // Reduced-frame golden model: plain per-block sum over the stored image
    int fr_s[256];

    function automatic int exp_s(input int br, input int bc);
        int sum = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sum += fr_s[(br * 4 + r) * 16 + bc * 4 + c];
`ifdef DS_ROUND_EN
        return (sum + 8) >> 4;
`else
        return sum >> 4;
`endif
    endfunction

    task automatic send_small_frame(input bit stall);
        for (int i = 0; i < 256; i++) push_s(8'(fr_s[i]), stall);
    endtask

    task automatic check_small_frame(input string tag);
        chk({tag, "_nwr"}, dq_s.size(), 16);
        chk({tag, "_ndone"}, nd_s, 1);
        chk({tag, "_done_at"}, dw_s, 16);
        for (int k = 0; k < 16; k++) begin
            if (k < dq_s.size()) begin
                chk($sformatf("%s_data%0d", tag, k), dq_s[k], exp_s(k / 4, k % 4));
                chk($sformatf("%s_addr%0d", tag, k), aq_s[k], (k / 4 + 1) * 6 + (k % 4) + 1);
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_d, bad_a, nr;
        rst_n   = 1'b0;
        start_b = 1'b0; pv_b = 1'b0; px_b = '0;
        start_s = 1'b0; pv_s = 1'b0; px_s = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(pr_b), 0);
        chk("rst_wr", int'(wr_b), 0);
        chk("rst_data", int'(dat_b), 0);
        chk("rst_addr", int'(addr_b), 0);
        chk("rst_busy", int'(busy_b), 0);
        chk("rst_done", int'(done_b), 0);
        chk("rst_s_ready", int'(pr_s), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant 100 frame, no stalls
        clr_b();
        start_pulse_b();
        @(negedge clk);
        chk("t1_busy_run", int'(busy_b), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 224 * 224; i++) push_b(8'd100);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_nwr", dq_b.size(), 784);
        bad_d = 0; bad_a = 0;
        for (int k = 0; k < dq_b.size(); k++) begin
            if (dq_b[k] != 100) bad_d++;
            if (aq_b[k] != (k / 28 + 2) * 32 + (k % 28) + 2) bad_a++;
        end
        chk("t1_bad_data", bad_d, 0);
        chk("t1_bad_addr", bad_a, 0);
        if (dq_b.size() > 0) begin
            chk("t1_first_addr", aq_b[0], 66);
            chk("t1_last_addr", aq_b[dq_b.size() - 1], 957);
        end
        chk("t1_ndone", nd_b, 1);
        chk("t1_done_at", dw_b, 784);
        chk("t1_busy_idle", int'(busy_b), 0);

        // Block 0 zeros plus one 32; block 1 all 255
        clr_b();
        start_pulse_b();
        for (int i = 0; i < 7 * 224 + 16; i++) begin
            int r, c;
            r = i / 224;
            c = i % 224;
            if (r == 0 && c == 0) push_b(8'd32);
            else if (c >= 8 && c < 16) push_b(8'd255);
            else push_b(8'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t3_nwr", dq_b.size(), 2);
        if (dq_b.size() >= 2) begin
`ifdef DS_ROUND_EN
            chk("t3_blk0_data", dq_b[0], 1);
`else
            chk("t3_blk0_data", dq_b[0], 0);
`endif
            chk("t3_blk0_addr", aq_b[0], 66);
            chk("t3_blk1_data", dq_b[1], 255);
            chk("t3_blk1_addr", aq_b[1], 67);
        end
        chk("t3_busy_mid", int'(busy_b), 1);

        // Async reset mid-frame
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_wr", int'(wr_b), 0);
        chk("t5_data", int'(dat_b), 0);
        chk("t5_addr", int'(addr_b), 0);
        chk("t5_busy", int'(busy_b), 0);
        chk("t5_ready", int'(pr_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_b();
        pv_b = 1'b1;
        px_b = 8'd7;
        nr = 0;
        repeat (20) begin
            @(negedge clk);
            if (pr_b) nr++;
        end
        pv_b = 1'b0;
        chk("t5_ready_idle", nr, 0);
        chk("t5_nwr", dq_b.size(), 0);
        chk("t5_ndone", nd_b, 0);
        @(posedge clk); #1;

        // Ramp on the reduced instance
        for (int i = 0; i < 256; i++) fr_s[i] = i;
        clr_s();
        start_pulse_s();
        send_small_frame(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_small_frame("t6");

        // Random frame with random input stalls
        for (int i = 0; i < 256; i++) fr_s[i] = int'($urandom_range(255));
        clr_s();
        start_pulse_s();
        send_small_frame(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_small_frame("t2");

        // Restart after a partial frame
        for (int i = 0; i < 256; i++) fr_s[i] = int'($urandom_range(255));
        start_pulse_s();
        for (int i = 0; i < 100; i++) push_s(8'(fr_s[i]), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        clr_s();
        start_pulse_s();
        send_small_frame(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_small_frame("t4");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
